// File: rtl/scan_chain_driver.sv
// Scan-chain driver: streams CHAIN_LEN bits from a byte source into a scan chain, LSB first, one byte per LOAD/SHIFT pass.
// Defining SCAN_DRIVER_READBACK_EN adds DRAIN, which returns the bits displaced from the chain as bytes on cap_*.
module scan_chain_driver #(
  parameter int CHAIN_LEN = 144
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       run_req,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] cap_data,
  output logic       cap_valid,
  input  logic       cap_ready,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       processor_enable,
  output logic       busy,
  output logic       done
);

  localparam int NBYTES = CHAIN_LEN / 8;
  localparam int BW     = $clog2(NBYTES + 1);

`ifdef SCAN_DRIVER_READBACK_EN
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DRAIN, DONE} state_t;
  localparam logic [BW-1:0] LAST = BW'(NBYTES);
`else
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam logic [BW-1:0] LAST_M1 = BW'(NBYTES - 1);
`endif

  state_t        state, state_nxt;
  logic [BW-1:0] byte_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_byte;
  logic          last_bit;

  assign last_bit         = (bit_cnt == 3'd7);
  assign processor_enable = run_req & ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      shift_byte <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            byte_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            shift_byte <= in_data;
            bit_cnt    <= '0;
          end
        end
        SHIFT: begin
          // bit_cnt wraps to 0 on the eighth shift, ready for the next byte
          bit_cnt <= bit_cnt + 3'd1;
          if (last_bit) byte_cnt <= byte_cnt + BW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    done        = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        scan_enable = 1'b1;
        scan_in     = shift_byte[bit_cnt];
        if (last_bit) begin
`ifdef SCAN_DRIVER_READBACK_EN
          state_nxt = DRAIN;
`else
          state_nxt = (byte_cnt == LAST_M1) ? DONE : LOAD;
`endif
        end
      end
`ifdef SCAN_DRIVER_READBACK_EN
      DRAIN: begin
        // byte_cnt already counts the byte just shifted
        if (cap_ready) state_nxt = (byte_cnt == LAST) ? DONE : LOAD;
      end
`endif
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SCAN_DRIVER_READBACK_EN
  logic [7:0] cap_reg;

  // scan_out is sampled on the same edge that shifts the chain, so bit k holds the k-th bit out
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_reg <= '0;
    end else if (state == SHIFT) begin
      cap_reg[bit_cnt] <= scan_out;
    end
  end

  assign cap_data  = cap_reg;
  assign cap_valid = (state == DRAIN);
`else
  logic unused_inputs;

  assign unused_inputs = cap_ready ^ scan_out;
  assign cap_data      = '0;
  assign cap_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: an 8-bit and a 144-bit instance, each against a FIFO-of-bits chain model.
// Expectations follow SCAN_DRIVER_READBACK_EN so the bench suits either build.
module tb_scan_chain_driver;

  localparam int LB = 144;
  localparam int NB = LB / 8;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_req = 1'b1;

  logic       a_start = 0, a_in_valid = 0, a_cap_ready = 1, a_scan_out = 0;
  logic [7:0] a_in_data = '0;
  logic       a_in_ready, a_cap_valid, a_scan_enable, a_scan_in, a_pe, a_busy, a_done;
  logic [7:0] a_cap_data;

  logic       b_start = 0, b_in_valid = 0, b_cap_ready = 1, b_scan_out = 0;
  logic [7:0] b_in_data = '0;
  logic       b_in_ready, b_cap_valid, b_scan_enable, b_scan_in, b_pe, b_busy, b_done;
  logic [7:0] b_cap_data;

  always #5 clk = ~clk;

  scan_chain_driver #(.CHAIN_LEN(8)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .run_req(run_req),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .cap_data(a_cap_data), .cap_valid(a_cap_valid), .cap_ready(a_cap_ready),
    .scan_enable(a_scan_enable), .scan_in(a_scan_in), .scan_out(a_scan_out),
    .processor_enable(a_pe), .busy(a_busy), .done(a_done)
  );

  scan_chain_driver #(.CHAIN_LEN(LB)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .run_req(run_req),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .cap_data(b_cap_data), .cap_valid(b_cap_valid), .cap_ready(b_cap_ready),
    .scan_enable(b_scan_enable), .scan_in(b_scan_in), .scan_out(b_scan_out),
    .processor_enable(b_pe), .busy(b_busy), .done(b_done)
  );

  // Chain model: first bit in is first bit out; index 0 is what scan_out presents.
  logic qa[$];
  logic qb[$];
  logic pa_se = 0, pa_si = 0, pb_se = 0, pb_si = 0;

  int a_se_cnt, a_done_cnt, a_capv_cnt, a_pe_bad;
  int b_se_cnt, b_done_cnt, b_capv_cnt, b_pe_bad, b_busy_cnt;
  logic [7:0] a_si_bits, a_cap_last;
  logic [7:0] b_capq[$];
  logic [7:0] b_bytes[NB];
  logic [7:0] b_prev[NB];
  logic       pe_at_done, pe_after;

  // Each negedge applies the shift of the posedge just passed, then records what the next posedge will shift.
  always @(negedge clk) begin
    if (pa_se) begin
      void'(qa.pop_front());
      qa.push_back(pa_si);
    end
    if (pb_se) begin
      void'(qb.pop_front());
      qb.push_back(pb_si);
    end
    a_scan_out = qa[0];
    b_scan_out = qb[0];
    pa_se = a_scan_enable; pa_si = a_scan_in;
    pb_se = b_scan_enable; pb_si = b_scan_in;
    if (a_scan_enable) begin
      a_se_cnt++;
      a_si_bits = {a_scan_in, a_si_bits[7:1]};
    end
    if (a_done) a_done_cnt++;
    if (a_cap_valid) a_capv_cnt++;
    if (a_cap_valid && a_cap_ready) a_cap_last = a_cap_data;
    if (a_busy && a_pe) a_pe_bad++;
    if (b_scan_enable) b_se_cnt++;
    if (b_done) b_done_cnt++;
    if (b_busy) b_busy_cnt++;
    if (b_cap_valid) b_capv_cnt++;
    if (b_cap_valid && b_cap_ready) b_capq.push_back(b_cap_data);
    if (b_busy && b_pe) b_pe_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] qa_byte();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = qa[k];
    return v;
  endfunction

  function automatic logic [7:0] qb_byte(input int i);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = qb[8*i+k];
    return v;
  endfunction

  task automatic clr_a();
    a_se_cnt = 0; a_done_cnt = 0; a_capv_cnt = 0; a_pe_bad = 0; a_si_bits = '0;
  endtask

  task automatic check_outputs_idle(input string tag);
    chk({tag, "_busy"}, b_busy, 0);
    chk({tag, "_done"}, b_done, 0);
    chk({tag, "_in_ready"}, b_in_ready, 0);
    chk({tag, "_cap_valid"}, b_cap_valid, 0);
    chk({tag, "_cap_data"}, b_cap_data, 0);
    chk({tag, "_scan_enable"}, b_scan_enable, 0);
    chk({tag, "_scan_in"}, b_scan_in, 0);
  endtask

  // One full load of the 144-bit chain; rnd randomises in_valid/cap_ready, poke pulses start mid-SHIFT.
  task automatic run_b(input bit rnd, input bit poke);
    int idx;
    bit hs, seen, pulsed;
    for (int i = 0; i < NB; i++) b_bytes[i] = 8'($urandom);
    for (int i = 0; i < NB; i++) b_prev[i] = qb_byte(i);
    b_se_cnt = 0; b_done_cnt = 0; b_busy_cnt = 0; b_capv_cnt = 0; b_pe_bad = 0;
    b_capq.delete();
    idx = 0; seen = 0; pulsed = 0;
    b_start = 1'b1;
    b_in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    b_in_data = b_bytes[0];
    b_cap_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    for (int c = 0; c < 4000 && !seen; c++) begin
      hs = b_in_valid && b_in_ready;
      step();
      b_start = 1'b0;
      if (hs) idx++;
      if (poke && !pulsed && b_scan_enable) begin
        b_start = 1'b1;
        pulsed = 1;
      end
      if (b_done) seen = 1;
      b_in_valid = (idx < NB) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      b_in_data = b_bytes[(idx < NB) ? idx : NB - 1];
      b_cap_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    b_start = 1'b0;
    chk("b_done_reached", seen, 1);
    pe_at_done = b_pe;
    step();
    pe_after = b_pe;
    repeat (3) step();
  endtask

  task automatic check_b_chain(input string tag);
    for (int i = 0; i < NB; i++) chk({tag, "_chain_byte"}, qb_byte(i), b_bytes[i]);
  endtask

  task automatic check_b_readback(input string tag);
`ifdef SCAN_DRIVER_READBACK_EN
    chk({tag, "_cap_count"}, b_capq.size(), NB);
    for (int i = 0; i < NB && i < b_capq.size(); i++) chk({tag, "_cap_byte"}, b_capq[i], b_prev[i]);
`else
    chk({tag, "_cap_valid_never"}, b_capv_cnt, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] snap;
    int se_seen;
    for (int k = 0; k < 8; k++) qa.push_back(1'b0);
    for (int k = 0; k < LB; k++) qb.push_back(1'b0);
    clr_a();

    // reset state
    rst = 1'b1;
    step(); step();
    check_outputs_idle("reset");
    chk("reset_a_busy", a_busy, 0);
    chk("reset_pe", b_pe, 1);
    run_req = 1'b0; #1;
    chk("idle_pe_follows_low", b_pe, 0);
    run_req = 1'b1; #1;
    chk("idle_pe_follows_high", b_pe, 1);

    // start coinciding with rst is dropped
    b_start = 1'b1;
    step();
    chk("start_with_rst_busy", b_busy, 0);
    rst = 1'b0; b_start = 1'b0;
    step();
    chk("start_with_rst_after", b_busy, 0);

    // in_valid outside LOAD is ignored
    a_in_valid = 1'b1; a_in_data = 8'hA5; #1;
    chk("idle_in_ready", a_in_ready, 0);

    // 8-bit chain preloaded with 0x3C, load 0xA5
    for (int k = 0; k < 8; k++) begin
      snap = 8'h3C;
      qa[k] = snap[k];
    end
    step();
    clr_a();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int c = 0; c < 60 && !a_done; c++) step();
    chk("a_done_reached", a_done, 1);
    chk("a_pe_in_done", a_pe, 0);
    repeat (3) step();
    chk("a_done_pulses", a_done_cnt, 1);
    chk("a_scan_enable_cycles", a_se_cnt, 8);
    chk("a_scan_in_sequence", a_si_bits, 8'hA5);
    chk("a_chain_contents", qa_byte(), 8'hA5);
    chk("a_pe_while_busy", a_pe_bad, 0);
`ifdef SCAN_DRIVER_READBACK_EN
    chk("a_readback_byte", a_cap_last, 8'h3C);

    // stalled DRAIN: cap_data holds the old contents, chain stays frozen
    snap = qa_byte();
    clr_a();
    a_cap_ready = 1'b0; a_in_data = 8'hFF;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int c = 0; c < 60 && !a_cap_valid; c++) step();
    chk("a_drain_valid", a_cap_valid, 1);
    chk("a_drain_data", a_cap_data, snap);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("a_stall_valid", a_cap_valid, 1);
      chk("a_stall_data", a_cap_data, snap);
      chk("a_stall_scan_enable", a_scan_enable, 0);
    end
    a_cap_ready = 1'b1;
    for (int c = 0; c < 60 && !a_done; c++) step();
    chk("a_stall_done_reached", a_done, 1);
    repeat (2) step();
    chk("a_stall_se_cycles", a_se_cnt, 8);
    chk("a_stall_chain", qa_byte(), 8'hFF);
`else
    chk("a_cap_valid_never", a_capv_cnt, 0);
`endif
    a_in_valid = 1'b0;

    // 144-bit chain, random in_valid/cap_ready, stray start during SHIFT
    for (int k = 0; k < LB; k++) qb[k] = ($urandom_range(0, 1) == 1);
    step();
    run_b(1'b1, 1'b1);
    chk("b_rand_se_cycles", b_se_cnt, LB);
    chk("b_rand_done_pulses", b_done_cnt, 1);
    chk("b_rand_pe_busy", b_pe_bad, 0);
    chk("b_rand_pe_in_done", pe_at_done, 0);
    chk("b_rand_pe_after_done", pe_after, 1);
    check_b_chain("b_rand");
    check_b_readback("b_rand");

    // in_valid held high: load time is fixed
    run_b(1'b0, 1'b0);
`ifdef SCAN_DRIVER_READBACK_EN
    chk("b_full_cycles", b_busy_cnt + 1, LB + NB + 2 + NB);
`else
    chk("b_full_cycles", b_busy_cnt + 1, LB + NB + 2);
`endif
    chk("b_full_se_cycles", b_se_cnt, LB);
    check_b_chain("b_full");
    check_b_readback("b_full");

    // reset at SHIFT cycle 3 of byte 2
    b_done_cnt = 0;
    b_in_valid = 1'b1; b_in_data = 8'h5A; b_cap_ready = 1'b1;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    se_seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (b_scan_enable) begin
        if (se_seen == 19) break;
        se_seen++;
      end
      step();
    end
    chk("b_rst_point_reached", se_seen, 19);
    rst = 1'b1;
    step();
    rst = 1'b0; b_in_valid = 1'b0;
    check_outputs_idle("midload_rst");
    chk("midload_rst_pe", b_pe, 1);
    repeat (4) step();
    chk("midload_rst_no_done", b_done_cnt, 0);
    chk("midload_rst_stays_idle", b_busy, 0);

    run_b(1'b0, 1'b0);
    chk("b_restart_done_pulses", b_done_cnt, 1);
    chk("b_restart_se_cycles", b_se_cnt, LB);
    check_b_chain("b_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_chain_driver.md
SCAN_CHAIN_DRIVER -- requirements
Module: scan_chain_driver

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 144, meaning total scan-chain length in bits; legal values are multiples of 8, from 8 to 4096.
REQ-002 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a full-chain load; sampled only in IDLE.
REQ-005 SHALL have port run_req  input  1  host request to let the processor run.
REQ-006 SHALL have port in_data  input  8  next chain byte, shifted LSB first.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  byte accepted on the cycle where in_valid and in_ready are both high.
REQ-009 SHALL have port cap_data  output  8  captured chain byte; the first bit out of the chain lands in bit 0.
REQ-010 SHALL have port cap_valid  output  1  cap_data valid.
REQ-011 SHALL have port cap_ready  input  1  consumer accepts cap_data.
REQ-012 SHALL have port scan_enable  output  1  drives the chain's scan_enable.
REQ-013 SHALL have port scan_in  output  1  drives the chain's scan_in.
REQ-014 SHALL have port scan_out  input  1  taken from the chain's scan_out.
REQ-015 SHALL have port processor_enable  output  1  equals run_req AND NOT busy.
REQ-016 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse when a load completes.

Function
REQ-018 SHALL implement the states IDLE, LOAD, SHIFT, DRAIN and DONE.
REQ-019 IDLE: start=1 SHALL move to LOAD and clear byte_cnt and bit_cnt.
REQ-020 LOAD: in_ready=1; a handshake SHALL latch in_data into the shift byte and move to SHIFT; with no handshake the state holds and scan_enable=0.
REQ-021 SHIFT: scan_enable=1 for exactly 8 consecutive cycles; in cycle k (0..7), scan_in = byte[k].
REQ-022 SHIFT: in cycle k, scan_out SHALL be sampled at the same clock edge into capture bit k.
REQ-023 After SHIFT cycle 7, byte_cnt SHALL increment; the next state is DRAIN if readback is compiled in, otherwise LOAD, or DONE when byte_cnt reaches CHAIN_LEN/8.
REQ-024 DRAIN: cap_valid=1 and cap_data = the captured byte, held stable until cap_ready=1.
REQ-025 DRAIN exit on a cap handshake: to LOAD if bytes remain, otherwise to DONE.
REQ-026 DONE: done=1 for one cycle, then IDLE.
REQ-027 scan_enable SHALL never be high outside SHIFT, so a stall leaves the chain frozen and unshifted.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 processor_enable SHALL be 0 in every cycle with busy=1, including the DONE cycle, and SHALL follow run_req combinationally in IDLE.
REQ-030 byte_cnt SHALL be sized ceil(log2(CHAIN_LEN/8+1)) bits and SHALL never wrap during a load.
REQ-031 in_valid outside LOAD SHALL be ignored, with in_ready=0.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, in_ready=0, cap_valid=0, cap_data=0, scan_enable=0, scan_in=0, and clear both counters.
REQ-033 rst asserted mid-load SHALL abandon the load without a done pulse; chain contents are then undefined, and the host must restart.
REQ-034 A start that coincides with rst SHALL be ignored.

Configuration
REQ-035 SHALL define a macro SCAN_DRIVER_READBACK_EN. When it is defined, DRAIN exists and captured bytes are output per REQ-024..025.
REQ-036 When SCAN_DRIVER_READBACK_EN is undefined, DRAIN and the capture register are omitted and cap_valid and cap_data are tied to 0; SHIFT goes straight to LOAD or DONE, and cap_ready is unused.

Verification
REQ-037 CHAIN_LEN=8, start, in_data=0xA5 presented immediately -> scan_in sequence 1,0,1,0,0,1,0,1 with scan_enable high for exactly 8 cycles; done pulses once; the chain model holds 0xA5.
REQ-038 Readback on, chain preloaded with 0x3C, load 0xFF -> cap_data=0x3C and cap_valid held; with cap_ready low for 5 cycles, cap_data stays stable and scan_enable stays 0.
REQ-039 CHAIN_LEN=144, in_valid toggled randomly -> exactly 144 scan_enable cycles total; the model chain equals the 18 input bytes; processor_enable=0 throughout with run_req=1, and returns to 1 the cycle after DONE.
REQ-040 rst asserted at SHIFT cycle 3 of byte 2 -> next cycle IDLE with all outputs at reset values and no done pulse; a subsequent start performs a full load.
REQ-041 Readback off -> cap_valid never asserts; 144-bit load completes in 144 + 18 + 2 cycles with in_valid held high.
REQ-042 start pulsed during SHIFT -> ignored; only one done pulse occurs and byte_cnt is unaffected.
